// File: rtl/btb_update_sched.sv
`default_nettype none
// ============================================================================
//  Module   : btb_update_sched
//  Purpose  : BTB write-port scheduler. Queues resolved branch updates from
//             two resolution ports and drains one write per cycle; runs an
//             invalidate sweep after reset and on fence_i.
//  Revision : 1.0  initial release
// ============================================================================
module btb_update_sched #(
    parameter  int ENTRIES    = 2,
    parameter  int FIFO_DEPTH = 4,
    localparam int IDX_W      = $clog2(ENTRIES),
    localparam int TAG_W      = 32 - IDX_W - 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fence_i,
    input  logic              br0_valid,
    output logic              br0_ready,
    input  logic [31:0]       br0_pc,
    input  logic [31:0]       br0_target,
    input  logic              br1_valid,
    output logic              br1_ready,
    input  logic [31:0]       br1_pc,
    input  logic [31:0]       br1_target,
    output logic              btb_wr_en,
    output logic [IDX_W-1:0]  btb_wr_idx,
    output logic [TAG_W-1:0]  btb_wr_tag,
    output logic [31:0]       btb_wr_target,
    output logic              btb_wr_valid,
    output logic              btb_busy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [0:0]       c_st_sweep = 1'b0;
    localparam logic [0:0]       c_st_run   = 1'b1;
    localparam logic [CNT_W-1:0] c_depth    = CNT_W'(FIFO_DEPTH);
    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(ENTRIES - 1);

    logic [0:0]       r_state_q,     w_state_d;
    logic [IDX_W-1:0] r_sweep_cnt_q, w_sweep_cnt_d;
    logic [PTR_W-1:0] r_rd_ptr_q,    w_rd_ptr_d;
    logic [PTR_W-1:0] r_wr_ptr_q,    w_wr_ptr_d;
    logic [CNT_W-1:0] r_count_q,     w_count_d;

    // Entries keep pc[31:2]; the low IDX_W bits are the index, the rest the tag.
    logic [29:0]      r_fpc_q  [FIFO_DEPTH];
    logic [29:0]      w_fpc_d  [FIFO_DEPTH];
    logic [31:0]      r_ftgt_q [FIFO_DEPTH];
    logic [31:0]      w_ftgt_d [FIFO_DEPTH];

    logic [CNT_W-1:0] w_free;
    logic [CNT_W-1:0] w_need1;
    logic             w_push0;
    logic             w_push1;
    logic             w_pop;
    logic [PTR_W-1:0] w_wr1_ptr;
    logic [29:0]      w_head_pc;

    // Space check uses the registered count only, so a same-cycle pop never
    // creates room and ready has no dependence on the drain path.
    always_comb begin
        w_free    = c_depth - r_count_q;
        w_need1   = br0_valid ? CNT_W'(2) : CNT_W'(1);
        br0_ready = !rst && !fence_i && (w_free >= CNT_W'(1));
        br1_ready = !rst && !fence_i && (w_free >= w_need1);
        w_push0   = br0_valid && br0_ready;
        w_push1   = br1_valid && br1_ready;
        w_pop     = (r_state_q == c_st_run) && (r_count_q != '0);
        w_wr1_ptr = r_wr_ptr_q + PTR_W'(w_push0);
        w_head_pc = r_fpc_q[r_rd_ptr_q];
    end

    always_comb begin
        btb_wr_en     = 1'b0;
        btb_wr_valid  = 1'b0;
        btb_wr_idx    = '0;
        btb_wr_tag    = '0;
        btb_wr_target = '0;
        btb_busy      = 1'b1;
        if (!rst) begin
            if (r_state_q == c_st_sweep) begin
                btb_wr_en  = 1'b1;
                btb_wr_idx = r_sweep_cnt_q;
            end else begin
                btb_busy = 1'b0;
                if (r_count_q != '0) begin
                    btb_wr_en     = 1'b1;
                    btb_wr_valid  = 1'b1;
                    btb_wr_idx    = w_head_pc[IDX_W-1:0];
                    btb_wr_tag    = w_head_pc[29:IDX_W];
                    btb_wr_target = r_ftgt_q[r_rd_ptr_q];
                end
            end
        end
    end

    always_comb begin
        w_state_d     = r_state_q;
        w_sweep_cnt_d = r_sweep_cnt_q;
        w_rd_ptr_d    = r_rd_ptr_q;
        w_wr_ptr_d    = r_wr_ptr_q;
        w_count_d     = r_count_q;
        w_fpc_d       = r_fpc_q;
        w_ftgt_d      = r_ftgt_q;

        if (w_push0) begin
            w_fpc_d[r_wr_ptr_q]  = br0_pc[31:2];
            w_ftgt_d[r_wr_ptr_q] = br0_target;
        end
        if (w_push1) begin
            w_fpc_d[w_wr1_ptr]  = br1_pc[31:2];
            w_ftgt_d[w_wr1_ptr] = br1_target;
        end

        if (fence_i) begin
            // The write shown this cycle still lands; the new sweep erases it.
            w_state_d     = c_st_sweep;
            w_sweep_cnt_d = '0;
            w_rd_ptr_d    = '0;
            w_wr_ptr_d    = '0;
            w_count_d     = '0;
        end else begin
            if (r_state_q == c_st_sweep) begin
                w_sweep_cnt_d = r_sweep_cnt_q + IDX_W'(1);
                if (r_sweep_cnt_q == c_last_idx) begin
                    w_sweep_cnt_d = '0;
                    w_state_d     = c_st_run;
                end
            end
            w_wr_ptr_d = r_wr_ptr_q + PTR_W'(w_push0) + PTR_W'(w_push1);
            w_rd_ptr_d = r_rd_ptr_q + PTR_W'(w_pop);
            w_count_d  = r_count_q + CNT_W'(w_push0) + CNT_W'(w_push1) - CNT_W'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q     <= c_st_sweep;
            r_sweep_cnt_q <= '0;
            r_rd_ptr_q    <= '0;
            r_wr_ptr_q    <= '0;
            r_count_q     <= '0;
        end else begin
            r_state_q     <= w_state_d;
            r_sweep_cnt_q <= w_sweep_cnt_d;
            r_rd_ptr_q    <= w_rd_ptr_d;
            r_wr_ptr_q    <= w_wr_ptr_d;
            r_count_q     <= w_count_d;
        end
    end

    // Payload storage is qualified by count, so it needs no reset.
    always_ff @(posedge clk) begin
        r_fpc_q  <= w_fpc_d;
        r_ftgt_q <= w_ftgt_d;
    end

endmodule
`default_nettype wire

// File: tb/tb_btb_update_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_btb_update_sched
//  Purpose  : Self-checking bench for btb_update_sched against a queue model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_btb_update_sched;

    localparam int ENTRIES    = 2;
    localparam int FIFO_DEPTH = 4;
    localparam int IDX_W      = $clog2(ENTRIES);
    localparam int TAG_W      = 32 - IDX_W - 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              fence_i = 1'b0;
    logic              br0_valid = 1'b0;
    logic [31:0]       br0_pc = '0;
    logic [31:0]       br0_target = '0;
    logic              br1_valid = 1'b0;
    logic [31:0]       br1_pc = '0;
    logic [31:0]       br1_target = '0;
    logic              br0_ready;
    logic              br1_ready;
    logic              btb_wr_en;
    logic [IDX_W-1:0]  btb_wr_idx;
    logic [TAG_W-1:0]  btb_wr_tag;
    logic [31:0]       btb_wr_target;
    logic              btb_wr_valid;
    logic              btb_busy;

    btb_update_sched #(.ENTRIES(ENTRIES), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .rst(rst), .fence_i(fence_i),
        .br0_valid(br0_valid), .br0_ready(br0_ready), .br0_pc(br0_pc), .br0_target(br0_target),
        .br1_valid(br1_valid), .br1_ready(br1_ready), .br1_pc(br1_pc), .br1_target(br1_target),
        .btb_wr_en(btb_wr_en), .btb_wr_idx(btb_wr_idx), .btb_wr_tag(btb_wr_tag),
        .btb_wr_target(btb_wr_target), .btb_wr_valid(btb_wr_valid), .btb_busy(btb_busy)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: pending updates in program order, plus sweep steps still owed.
    typedef struct packed { logic [31:0] pc; logic [31:0] tgt; } ent_t;
    ent_t m_q[$];
    int   m_left = ENTRIES;

    function automatic bit m_rdy0();
        return !rst && !fence_i && ((FIFO_DEPTH - m_q.size()) >= 1);
    endfunction
    function automatic bit m_rdy1();
        return !rst && !fence_i && ((FIFO_DEPTH - m_q.size()) >= (br0_valid ? 2 : 1));
    endfunction

    always @(posedge clk) begin
        bit   p0, p1;
        ent_t e0, e1;
        p0 = br0_valid && m_rdy0();
        p1 = br1_valid && m_rdy1();
        e0 = '{pc: br0_pc, tgt: br0_target};
        e1 = '{pc: br1_pc, tgt: br1_target};
        if (rst || fence_i) begin
            m_left = ENTRIES;
            m_q.delete();
        end else begin
            if (m_left > 0) m_left--;
            else if (m_q.size() > 0) void'(m_q.pop_front());
            if (p0) m_q.push_back(e0);
            if (p1) m_q.push_back(e1);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic        e_en, e_val, e_busy;
            logic [31:0] e_idx, e_tag, e_tgt;
            e_en = 0; e_val = 0; e_busy = 1; e_idx = 0; e_tag = 0; e_tgt = 0;
            if (!rst) begin
                if (m_left > 0) begin
                    e_en  = 1;
                    e_idx = ENTRIES - m_left;
                end else begin
                    e_busy = 0;
                    if (m_q.size() > 0) begin
                        e_en  = 1;
                        e_val = 1;
                        e_idx = 32'(m_q[0].pc[IDX_W+1:2]);
                        e_tag = m_q[0].pc >> (IDX_W + 2);
                        e_tgt = m_q[0].tgt;
                    end
                end
            end
            chk("m_br0_ready", 32'(br0_ready), 32'(m_rdy0()));
            chk("m_br1_ready", 32'(br1_ready), 32'(m_rdy1()));
            chk("m_wr_en",     32'(btb_wr_en), 32'(e_en));
            chk("m_busy",      32'(btb_busy),  32'(e_busy));
            if (e_en || rst) begin
                chk("m_wr_valid",  32'(btb_wr_valid), 32'(e_val));
                chk("m_wr_idx",    32'(btb_wr_idx),   e_idx);
                chk("m_wr_tag",    32'(btb_wr_tag),   e_tag);
                chk("m_wr_target", btb_wr_target,     e_tgt);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        br0_valid = 0; br1_valid = 0; fence_i = 0;
    endtask

    task automatic drv(input logic [31:0] p0, input logic [31:0] t0,
                       input logic [31:0] p1, input logic [31:0] t1);
        br0_valid = 1; br0_pc = p0; br0_target = t0;
        br1_valid = 1; br1_pc = p1; br1_target = t1;
    endtask

    initial begin
        rst = 1; idle();
        step(); chk_en = 1; step(); step();

        // Reset release: two sweep cycles, then idle RUN
        rst = 0; #1;
        chk("t1_en_c1", 32'(btb_wr_en), 1);
        chk("t1_val_c1", 32'(btb_wr_valid), 0);
        chk("t1_idx_c1", 32'(btb_wr_idx), 0);
        chk("t1_busy_c1", 32'(btb_busy), 1);
        step(); #1;
        chk("t1_idx_c2", 32'(btb_wr_idx), 1);
        chk("t1_busy_c2", 32'(btb_busy), 1);
        step(); #1;
        chk("t1_busy_c3", 32'(btb_busy), 0);
        chk("t1_en_c3", 32'(btb_wr_en), 0);

        // Single update, written the next cycle
        br0_valid = 1; br0_pc = 32'h0000_0104; br0_target = 32'h0000_0200; #1;
        chk("t2_rdy0", 32'(br0_ready), 1);
        step(); br0_valid = 0; #1;
        chk("t2_en", 32'(btb_wr_en), 1);
        chk("t2_idx", 32'(btb_wr_idx), 1);
        chk("t2_tag", 32'(btb_wr_tag), 32'h20);
        chk("t2_tgt", btb_wr_target, 32'h200);
        chk("t2_val", 32'(btb_wr_valid), 1);
        step(); #1;
        chk("t2_en_after", 32'(btb_wr_en), 0);

        // Dual-port fill to free=1, ordering port 0 before port 1
        drv(32'h1000, 32'hA000, 32'h1004, 32'hA004);
        step();
        drv(32'h1008, 32'hA008, 32'h100C, 32'hA00C); #1;
        chk("t3_head_a", btb_wr_target, 32'hA000);
        step();
        drv(32'h1010, 32'hA010, 32'h1014, 32'hA014); #1;
        chk("t3_rdy0", 32'(br0_ready), 1);
        chk("t3_rdy1", 32'(br1_ready), 0);
        chk("t3_head_b", btb_wr_target, 32'hA004);
        step();
        br0_valid = 0; #1;
        chk("t3_rdy1_hold", 32'(br1_ready), 1);
        step(); idle();
        repeat (5) step();
        #1;
        chk("t3_drained", 32'(btb_wr_en), 0);

        // fence_i with three queued entries
        drv(32'h2000, 32'hB000, 32'h2004, 32'hB004);
        step();
        drv(32'h2008, 32'hB008, 32'h200C, 32'hB00C);
        step(); idle();
        fence_i = 1; drv(32'h2010, 32'hB010, 32'h2014, 32'hB014); #1;
        chk("t5_rdy0", 32'(br0_ready), 0);
        chk("t5_rdy1", 32'(br1_ready), 0);
        chk("t5_en", 32'(btb_wr_en), 1);
        step(); idle(); #1;
        chk("t5_sw0", 32'(btb_wr_idx), 0);
        chk("t5_busy", 32'(btb_busy), 1);
        step(); #1;
        chk("t5_sw1", 32'(btb_wr_idx), 1);
        step(); #1;
        chk("t5_en_after", 32'(btb_wr_en), 0);
        chk("t5_busy_after", 32'(btb_busy), 0);

        // Fill to full during a sweep, then drain in order
        fence_i = 1;
        step(); fence_i = 0;
        drv(32'h3000, 32'hC000, 32'h3004, 32'hC004); #1;
        chk("t4_rdy_sweep", 32'(br1_ready), 1);
        step();
        drv(32'h3008, 32'hC008, 32'h300C, 32'hC00C);
        step();
        drv(32'h3010, 32'hC010, 32'h3014, 32'hC014); #1;
        chk("t4_full_rdy0", 32'(br0_ready), 0);
        chk("t4_full_rdy1", 32'(br1_ready), 0);
        chk("t4_w0", btb_wr_target, 32'hC000);
        step(); idle(); #1;
        chk("t4_w1", btb_wr_target, 32'hC004);
        step(); #1;
        chk("t4_w2", btb_wr_target, 32'hC008);
        step(); #1;
        chk("t4_w3", btb_wr_target, 32'hC00C);
        step(); #1;
        chk("t4_empty", 32'(btb_wr_en), 0);

        // Reset mid-sweep, then fence_i mid-sweep
        fence_i = 1;
        step(); fence_i = 0;
        step(); #1;
        chk("t6_pre_idx1", 32'(btb_wr_idx), 1);
        rst = 1; br0_valid = 1; br0_pc = 32'h4000; br0_target = 32'hD000; #1;
        chk("t6_rst_en", 32'(btb_wr_en), 0);
        chk("t6_rst_rdy0", 32'(br0_ready), 0);
        step(); rst = 0; br0_valid = 0; #1;
        chk("t6_restart_idx", 32'(btb_wr_idx), 0);
        chk("t6_restart_rdy0", 32'(br0_ready), 1);
        step(); fence_i = 1; #1;
        chk("t6_fence_idx1", 32'(btb_wr_idx), 1);
        step(); fence_i = 0; #1;
        chk("t6_refence_idx", 32'(btb_wr_idx), 0);
        step(); step();
        drv(32'h4004, 32'hD004, 32'h4008, 32'hD008); #1;
        chk("t6_rdy1", 32'(br1_ready), 1);
        step(); idle();
        repeat (3) step();
        #1;
        chk("t6_final_en", 32'(btb_wr_en), 0);

        @(posedge clk);
        chk_en = 0;
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
